// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser plus whole-word stability filter.
// The synchronised word must hold unchanged for STABLE_CYCLES cycles before
// it is published on dout; each accepted update is flagged on `changed`.
// Optional feature macro: SWDB_STICKY_EN -- adds `ack` and makes `changed`
// a sticky flag that stays set until acknowledged.
module switch_debouncer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches,
`ifdef SWDB_STICKY_EN
  input  logic             ack,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             changed,
  output logic             busy
);

  localparam logic [15:0] STABLE_CNT = 16'(STABLE_CYCLES);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sync0_q, sync1_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             changed_q, changed_d;
  logic             busy_q, busy_d;
  logic             commit;

  // Two-stage synchroniser on every bit; only sync1 is used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= switches;
      sync1_q <= sync0_q;
    end
  end

  // Qualification FSM: any bit change restarts the count for the whole word.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync1_q != dout_q) begin
          cand_d  = sync1_q;
          cnt_d   = 16'd1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (sync1_q != cand_q) begin
          if (sync1_q == dout_q) begin
            // Bounced back to the published value: drop the candidate.
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            // Moved to yet another value: restart with it as candidate.
            cand_d = sync1_q;
            cnt_d  = 16'd1;
          end
        end else if (cnt_q == STABLE_CNT) begin
          dout_d  = cand_q;
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Change flag: one-cycle strobe, or sticky until ack (set beats ack).
  always_comb begin
`ifdef SWDB_STICKY_EN
    changed_d = commit | (changed_q & ~ack);
`else
    changed_d = commit;
`endif
    busy_d = (state_d == COUNT);
  end

  // State and output registers; reset discards any candidate in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
    end
  end

  assign dout    = dout_q;
  assign changed = changed_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (STABLE_CYCLES=4): directed scenarios followed
// by randomized bouncing stimulus, all checked against a run-length model.
module tb_switch_debouncer;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] switches;
  logic [31:0] dout;
  logic        changed;
  logic        busy;
`ifdef SWDB_STICKY_EN
  logic        ack = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  switch_debouncer #(.WIDTH(32), .STABLE_CYCLES(SC)) dut (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
`ifdef SWDB_STICKY_EN
    .ack      (ack),
`endif
    .dout     (dout),
    .changed  (changed),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: the word seen downstream is the input delayed by two
  // edges; a value is published once it has been seen on STABLE_CYCLES+1
  // consecutive edges while differing from the published word.
  logic [31:0] m_d1, m_d2, m_last, m_dout;
  int          m_run;
  logic        m_chg, m_busy;

  task automatic m_reset();
    m_d1 = '0; m_d2 = '0; m_last = '0; m_dout = '0;
    m_run = 0; m_chg = 1'b0; m_busy = 1'b0;
  endtask

  task automatic m_edge(input logic [31:0] sw);
    logic [31:0] s;
    logic        commit;
    s    = m_d2;
    m_d2 = m_d1;
    m_d1 = sw;
    m_run  = (s == m_last) ? m_run + 1 : 1;
    m_last = s;
    commit = (s != m_dout) && (m_run == SC + 1);
    if (commit) m_dout = s;
`ifdef SWDB_STICKY_EN
    m_chg = commit | (m_chg & ~ack);
`else
    m_chg = commit;
`endif
    m_busy = (s != m_dout);
  endtask

  task automatic step(input logic [31:0] sw);
    switches = sw;
    @(posedge clk);
    m_edge(sw);
    #1;
    chk("dout", dout, m_dout);
    chk("changed", {31'b0, changed}, {31'b0, m_chg});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
  endtask

  // Drive a value long enough to publish it, leaving the change flag clear.
  task automatic settle(input logic [31:0] v);
`ifdef SWDB_STICKY_EN
    ack = 1'b1;
`endif
    repeat (10) step(v);
`ifdef SWDB_STICKY_EN
    ack = 1'b0;
`endif
  endtask

  int          busy_cnt, rises;
  logic        prev_chg, saw_one;
  logic [31:0] cur, tgt;

  initial begin
    // Reset value with nonzero switches present.
    reset    = 1'b1;
    switches = 32'h12345678;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 32'h0);
    chk("rst_changed", {31'b0, changed}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step(32'h12345678);
      if (i < 7) chk("rel_dout_early", dout, 32'h0);
    end
    chk("rel_dout", dout, 32'h12345678);
    chk("rel_changed", {31'b0, changed}, 32'h1);
`ifndef SWDB_STICKY_EN
    step(32'h12345678);
    chk("rel_strobe_len", {31'b0, changed}, 32'h0);
`endif

    // Clean change 0 -> FF.
    settle(32'h0);
    busy_cnt = 0; rises = 0; prev_chg = changed;
    for (int i = 0; i < 10; i++) begin
      step(32'h000000FF);
      if (busy) busy_cnt++;
      if (changed && !prev_chg) rises++;
      prev_chg = changed;
    end
    chk("clean_busy_cycles", busy_cnt, 4);
    chk("clean_pulses", rises, 1);
    chk("clean_dout", dout, 32'hFF);

    // Bounce back to the published value.
    settle(32'h0);
    rises = 0; prev_chg = changed;
    step(32'h1); step(32'h1);
    for (int i = 0; i < 8; i++) begin
      step(32'h0);
      if (changed && !prev_chg) rises++;
      prev_chg = changed;
    end
    chk("bounce_pulses", rises, 0);
    chk("bounce_dout", dout, 32'h0);
    chk("bounce_busy", {31'b0, busy}, 32'h0);

    // Bounce to a third value: 1 never published, 3 lands on step 9.
    saw_one = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(i <= 2 ? 32'h1 : 32'h3);
      if (dout == 32'h1) saw_one = 1'b1;
      if (i == 8) chk("third_dout_early", dout, 32'h0);
      if (i == 9) chk("third_dout", dout, 32'h3);
    end
    chk("third_never_one", {31'b0, saw_one}, 32'h0);

    // Reset mid-qualification: outputs clear without a clock edge.
    settle(32'h000000FF);
    repeat (3) step(32'hFFFF0000);
    chk("mid_busy", {31'b0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_dout", dout, 32'h0);
    chk("mid_rst_changed", {31'b0, changed}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) step(32'hFFFF0000);
    chk("mid_requal", dout, 32'hFFFF0000);

`ifdef SWDB_STICKY_EN
    // Sticky flag holds until ack; commit beats a simultaneous ack.
    settle(32'h0);
    repeat (7) step(32'hA5);
    chk("sticky_set", {31'b0, changed}, 32'h1);
    repeat (3) step(32'hA5);
    chk("sticky_hold", {31'b0, changed}, 32'h1);
    ack = 1'b1;
    step(32'hA5);
    ack = 1'b0;
    chk("sticky_clear", {31'b0, changed}, 32'h0);
    ack = 1'b1;
    repeat (7) step(32'h5A);
    chk("sticky_set_wins", {31'b0, changed}, 32'h1);
    step(32'h5A);
    chk("sticky_ack_after", {31'b0, changed}, 32'h0);
    ack = 1'b0;
`endif

    // Randomized bursts of bounce followed by holds of random length.
    cur = dout;
    for (int n = 0; n < 120; n++) begin
      tgt = ($urandom_range(0, 1) == 0) ? $urandom() : (cur ^ (32'h1 << $urandom_range(0, 31)));
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
`ifdef SWDB_STICKY_EN
        ack = ($urandom_range(0, 3) == 0);
`endif
        step(($urandom_range(0, 1) == 0) ? cur : $urandom());
      end
      for (int h = 0; h < int'($urandom_range(1, 9)); h++) begin
`ifdef SWDB_STICKY_EN
        ack = ($urandom_range(0, 3) == 0);
`endif
        step(tgt);
      end
      cur = tgt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
